// File: rtl/mt9v034_pkg.sv
// Shared constants for the MT9V034 two-wire configuration master.
// State encodings, camera address and commonly used register addresses.
package mt9v034_pkg;

   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h5C;

   localparam logic [7:0]  REG_CHIP_VERSION = 8'h00;
   localparam logic [7:0]  REG_RESET        = 8'h0C;
   localparam logic [7:0]  REG_READ_MODE    = 8'h0D;
   localparam logic [15:0] CHIP_VERSION_ID  = 16'h1324;

   localparam int STATE_W = 4;

   localparam logic [STATE_W-1:0] ENC_IDLE   = 4'd0;
   localparam logic [STATE_W-1:0] ENC_START  = 4'd1;
   localparam logic [STATE_W-1:0] ENC_ADDR_W = 4'd2;
   localparam logic [STATE_W-1:0] ENC_REG    = 4'd3;
   localparam logic [STATE_W-1:0] ENC_WR_H   = 4'd4;
   localparam logic [STATE_W-1:0] ENC_WR_L   = 4'd5;
   localparam logic [STATE_W-1:0] ENC_RSTART = 4'd6;
   localparam logic [STATE_W-1:0] ENC_ADDR_R = 4'd7;
   localparam logic [STATE_W-1:0] ENC_RD_H   = 4'd8;
   localparam logic [STATE_W-1:0] ENC_RD_L   = 4'd9;
   localparam logic [STATE_W-1:0] ENC_STOP   = 4'd10;
   localparam logic [STATE_W-1:0] ENC_DONE   = 4'd11;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_START  = ENC_START,
      ST_ADDR_W = ENC_ADDR_W,
      ST_REG    = ENC_REG,
      ST_WR_H   = ENC_WR_H,
      ST_WR_L   = ENC_WR_L,
      ST_RSTART = ENC_RSTART,
      ST_ADDR_R = ENC_ADDR_R,
      ST_RD_H   = ENC_RD_H,
      ST_RD_L   = ENC_RD_L,
      ST_STOP   = ENC_STOP,
      ST_DONE   = ENC_DONE
   } state_t;

   function automatic logic [7:0] dev_byte(
      input logic [6:0] addr,
      input logic       rd
   );
      return {addr, rd};
   endfunction

endpackage

// File: rtl/mt9v034_i2c_tick_gen.sv
// Quarter-bit tick generator: CLK_DIV divider plus 2-bit phase counter.
// Both counters sit at zero whenever the enable is low.
module i2c_tick_gen #(
   parameter int CLK_DIV = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic       qtick,
   output logic [1:0] phase
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign qtick = en && (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt   <= '0;
         phase <= '0;
      end else if (qtick) begin
         cnt   <= '0;
         phase <= phase + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mt9v034_i2c_master.sv
// Two-wire master running one 16-bit register write or read per request.
// Every bit slot is four quarter phases; SCL/SDA are registered from state.
module mt9v034_i2c_master
   import mt9v034_pkg::*;
#(
   parameter int         CLK_DIV  = 120,
   parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rw,
   input  logic [7:0]  reg_addr,
   input  logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic [15:0] rd_data,
   output logic        scl_o,
   output logic        sda_oe,
   input  logic        sda_i
);

   state_t      state;
   logic [3:0]  bitcnt;
   logic        rw_q;
   logic [7:0]  addr_q;
   logic [15:0] wdata_q;
   logic [15:0] shreg;
   logic        ack_bit;

   logic        qtick;
   logic [1:0]  phase;
   logic        tick_en;
   logic        slot_end;
   logic        sample;
   logic        ack_slot;
   logic        master_tx;
   logic [7:0]  tx_byte;
   logic        scl_n;
   logic        sda_n;

   assign tick_en   = (state != ST_IDLE) && (state != ST_DONE);
   assign slot_end  = qtick && (phase == 2'd3);
   assign sample    = qtick && (phase == 2'd2);
   assign ack_slot  = (bitcnt == 4'd8);
   assign master_tx = (state != ST_RD_H) && (state != ST_RD_L);

   i2c_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (tick_en),
      .qtick (qtick),
      .phase (phase)
   );

   always_comb begin
      tx_byte = 8'hFF;
      unique case (state)
         ST_ADDR_W: tx_byte = dev_byte(DEV_ADDR, 1'b0);
         ST_REG:    tx_byte = addr_q;
         ST_WR_H:   tx_byte = wdata_q[15:8];
         ST_WR_L:   tx_byte = wdata_q[7:0];
         ST_ADDR_R: tx_byte = dev_byte(DEV_ADDR, 1'b1);
         default:   tx_byte = 8'hFF;
      endcase
   end

   // Bus levels for the current slot/phase; registered below.
   always_comb begin
      scl_n = 1'b1;
      sda_n = 1'b0;
      unique case (state)
         ST_START: begin
            sda_n = phase[1];
         end
         ST_ADDR_W, ST_REG, ST_WR_H, ST_WR_L, ST_ADDR_R: begin
            scl_n = phase[1];
            sda_n = !ack_slot && !tx_byte[3'd7 - bitcnt[2:0]];
         end
         ST_RD_H: begin
            scl_n = phase[1];
            sda_n = ack_slot;
         end
         ST_RD_L: begin
            scl_n = phase[1];
         end
         ST_RSTART: begin
            scl_n = (phase != 2'd0);
            sda_n = (phase == 2'd3);
         end
         ST_STOP: begin
            scl_n = (phase != 2'd0);
            sda_n = (phase != 2'd3);
         end
         default: begin
            scl_n = 1'b1;
            sda_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         bitcnt  <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         shreg   <= '0;
         ack_bit <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         ack_err <= 1'b0;
         rd_data <= '0;
         scl_o   <= 1'b1;
         sda_oe  <= 1'b0;
      end else begin
         scl_o <= scl_n;
         sda_oe <= sda_n;
         done  <= 1'b0;

         if (sample) begin
            if (ack_slot) begin
               ack_bit <= sda_i;
            end else if (!master_tx) begin
               shreg <= {shreg[14:0], sda_i};
            end
         end

         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  rw_q    <= rw;
                  addr_q  <= reg_addr;
                  wdata_q <= wr_data;
                  bitcnt  <= '0;
                  busy    <= 1'b1;
                  ack_err <= 1'b0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (slot_end) state <= ST_ADDR_W;
            end
            ST_RSTART: begin
               if (slot_end) state <= ST_ADDR_R;
            end
            ST_STOP: begin
               if (slot_end) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               if (slot_end) begin
                  if (!ack_slot) begin
                     bitcnt <= bitcnt + 4'd1;
                  end else begin
                     bitcnt <= '0;
                     // A NACK on any byte we sent aborts straight to STOP.
                     if (master_tx && ack_bit) begin
                        ack_err <= 1'b1;
                        state   <= ST_STOP;
                     end else begin
                        unique case (state)
                           ST_ADDR_W: state <= ST_REG;
                           ST_REG:    state <= rw_q ? ST_RSTART : ST_WR_H;
                           ST_WR_H:   state <= ST_WR_L;
                           ST_ADDR_R: state <= ST_RD_H;
                           ST_RD_H:   state <= ST_RD_L;
                           ST_RD_L: begin
                              rd_data <= shreg;
                              state   <= ST_STOP;
                           end
                           default:   state <= ST_STOP;
                        endcase
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mt9v034_i2c_master.sv
// Bench for mt9v034_i2c_master: bus-decoding slave model plus scoreboard.
module tb_mt9v034_i2c_master;

   localparam int DIV  = 4;
   localparam int SLOT = 4 * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rw;
   logic [7:0]  reg_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        ack_err;
   logic [15:0] rd_data;
   logic        scl_o;
   logic        sda_oe;
   logic        sda_i;

   logic        slv_pull = 1'b0;
   logic        nack_addr = 1'b0;
   logic [15:0] slv_word = 16'h1324;

   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;

   assign sda_i = !(sda_oe || slv_pull);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mt9v034_i2c_master #(
      .CLK_DIV  (DIV),
      .DEV_ADDR (7'h5C)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rw       (rw),
      .reg_addr (reg_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .rd_data  (rd_data),
      .scl_o    (scl_o),
      .sda_oe   (sda_oe),
      .sda_i    (sda_i)
   );

   typedef struct {
      int               n;
      logic [5:0][7:0]  b;
      logic [5:0]       a;
      logic             ack_err;
      logic [15:0]      rd;
      int               lat;
      int               starts;
      int               stops;
      int               n16;
      int               nother;
      longint           acc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Bus monitor / slave model
   logic [7:0] obs_b [0:7];
   logic       obs_a [0:7];
   int         obs_n = 0, obs_s = 0, obs_p = 0, n16 = 0, nother = 0;
   longint     last_rise = -1;
   logic [7:0] cur = '0;
   int         bitcnt = 0, bif = 0, rd_idx = 0;
   logic       read_mode = 1'b0, in_txn = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1, sda_now;

   initial begin
      forever begin
         @(negedge clk);
         sda_now = sda_i;
         if (reset || !busy) begin
            in_txn    = 1'b0;
            read_mode = 1'b0;
            slv_pull  = 1'b0;
         end else if (prev_scl && scl_o && prev_sda && !sda_now) begin
            if (!in_txn) begin
               in_txn = 1'b1;
               obs_n = 0; obs_s = 0; obs_p = 0;
               n16 = 0; nother = 0; last_rise = -1;
            end
            obs_s++;
            bitcnt = 0; bif = 0; rd_idx = 0;
            read_mode = 1'b0;
         end else if (prev_scl && scl_o && !prev_sda && sda_now) begin
            obs_p++;
            in_txn = 1'b0;
         end else if (!prev_scl && scl_o) begin
            if (last_rise >= 0) begin
               if (cyc - last_rise == SLOT) n16++;
               else nother++;
            end
            last_rise = cyc;
            if (bitcnt < 8) begin
               cur = {cur[6:0], sda_now};
               bitcnt++;
            end else begin
               if (obs_n < 8) begin
                  obs_b[obs_n] = cur;
                  obs_a[obs_n] = sda_now;
               end
               obs_n++;
               if (read_mode) begin
                  rd_idx++;
                  if (sda_now) read_mode = 1'b0;
               end else if (bif == 0 && cur == 8'hB9 && !sda_now) begin
                  read_mode = 1'b1;
                  rd_idx = 0;
               end
               bif++;
               bitcnt = 0;
            end
         end else if (prev_scl && !scl_o) begin
            if (read_mode) begin
               logic [7:0] rb;
               rb = (rd_idx == 0) ? slv_word[15:8] : slv_word[7:0];
               slv_pull = (bitcnt < 8) ? !rb[3'(7 - bitcnt)] : 1'b0;
            end else begin
               slv_pull = (bitcnt == 8) && !(nack_addr && bif == 0);
            end
         end
         prev_scl = scl_o;
         prev_sda = sda_now;
      end
   end

   // Scoreboard: compare each completed transaction with the queued model
   initial begin
      exp_t   e;
      longint lat;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no transaction");
            end else begin
               e = sb.pop_front();
               check("ack_err", 32'(ack_err), 32'(e.ack_err));
               check("rd_data", 32'(rd_data), 32'(e.rd));
               check("busy_at_done", 32'(busy), 32'd1);
               lat = cyc - e.acc;
               checks++;
               if (lat < e.lat - 2 || lat > e.lat + 2) begin
                  errors++;
                  $display("FAIL latency: got %0d expected %0d", lat, e.lat);
               end
               check("byte_count", 32'(obs_n), 32'(e.n));
               for (int i = 0; i < e.n && i < obs_n; i++) begin
                  check($sformatf("byte%0d", i), 32'(obs_b[i]), 32'(e.b[i]));
                  check($sformatf("ack%0d", i), 32'(obs_a[i]), 32'(e.a[i]));
               end
               check("starts", 32'(obs_s), 32'(e.starts));
               check("stops", 32'(obs_p), 32'(e.stops));
               check("scl_16clk_periods", 32'(n16), 32'(e.n16));
               check("scl_other_periods", 32'(nother), 32'(e.nother));
            end
         end
      end
   end

   logic [15:0] exp_rd = 16'h0000;

   task automatic issue(input logic r, input logic [7:0] a,
                        input logic [15:0] d, output longint acc);
      @(negedge clk);
      start = 1'b1; rw = r; reg_addr = a; wr_data = d;
      @(posedge clk);
      #1;
      acc = cyc;
      start = 1'b0; rw = ~r; reg_addr = 8'hFF; wr_data = 16'hDEAD;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic push_write(input logic [7:0] a, input logic [15:0] d,
                             input longint acc);
      exp_t e;
      e.n = 4; e.b = '0; e.a = '0;
      e.b[0] = 8'hB8; e.b[1] = a; e.b[2] = d[15:8]; e.b[3] = d[7:0];
      e.ack_err = 1'b0; e.rd = exp_rd; e.lat = 38 * SLOT;
      e.starts = 1; e.stops = 1; e.n16 = 35; e.nother = 1; e.acc = acc;
      sb.push_back(e);
   endtask

   task automatic push_read(input logic [7:0] a, input longint acc);
      exp_t e;
      e.n = 5; e.b = '0; e.a = '0;
      e.b[0] = 8'hB8; e.b[1] = a; e.b[2] = 8'hB9;
      e.b[3] = slv_word[15:8]; e.b[4] = slv_word[7:0];
      e.a[4] = 1'b1;
      exp_rd = slv_word;
      e.ack_err = 1'b0; e.rd = exp_rd; e.lat = 48 * SLOT;
      e.starts = 2; e.stops = 1; e.n16 = 43; e.nother = 3; e.acc = acc;
      sb.push_back(e);
   endtask

   task automatic push_nack(input longint acc);
      exp_t e;
      e.n = 1; e.b = '0; e.a = '0;
      e.b[0] = 8'hB8; e.a[0] = 1'b1;
      e.ack_err = 1'b1; e.rd = exp_rd; e.lat = 11 * SLOT;
      e.starts = 1; e.stops = 1; e.n16 = 8; e.nother = 1; e.acc = acc;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=1 expected 0", name);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      longint acc;
      int     k;
      reset = 1'b1; start = 1'b0; rw = 1'b0;
      reg_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_scl", 32'(scl_o), 32'd1);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      issue(1'b0, 8'h0D, 16'h0330, acc);
      push_write(8'h0D, 16'h0330, acc);
      wait_idle("write");

      issue(1'b1, 8'h00, 16'h0000, acc);
      push_read(8'h00, acc);
      wait_idle("read");

      nack_addr = 1'b1;
      issue(1'b1, 8'h00, 16'h0000, acc);
      push_nack(acc);
      wait_idle("nack");
      nack_addr = 1'b0;

      issue(1'b0, 8'h0D, 16'hA55A, acc);
      push_write(8'h0D, 16'hA55A, acc);
      repeat (100) @(negedge clk);
      start = 1'b1; rw = 1'b1; reg_addr = 8'h00;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("start_in_done_ignored", 32'(busy), 32'd0);

      issue(1'b0, 8'h0C, 16'h0001, acc);
      repeat (20 * SLOT) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_scl", 32'(scl_o), 32'd1);
      check("midrst_sda_oe", 32'(sda_oe), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      exp_rd = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      issue(1'b0, 8'h0C, 16'h0001, acc);
      push_write(8'h0C, 16'h0001, acc);
      wait_idle("after_reset");

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mt9v034_i2c_master.md
Name: mt9v034_i2c_master

Overview:
- Two-wire serial master for MT9V034 register access.
- Runs one 16-bit register write or read per request: 8-bit register address, data sent MSB byte first.
- Replaces the ad-hoc SDA bit-banging in the camera top level.
- Sits between the camera configuration/debug logic (seven-seg display, switches) and the cam_i2c pins, in the 24 MHz domain.

Parameters:
- CLK_DIV, 120: clk cycles per quarter bit-period. Default gives 50 kHz SCL at 24 MHz.
- DEV_ADDR, 7'h5C: 7-bit camera address. Wire bytes are 0xB8 (write) and 0xB9 (read).

Ports:
- clk  in  1  24 MHz system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- rw  in  1  1 = read, 0 = write; latched with start
- reg_addr  in  8  register address; latched with start
- wr_data  in  16  write data; latched with start
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse when the transaction ends
- ack_err  out  1  valid with done; 1 = slave NACKed a master byte
- rd_data  out  16  read result; updated only on a successful read
- scl_o  out  1  SCL level, push-pull
- sda_oe  out  1  1 = pull SDA low, 0 = release (external pull-up)
- sda_i  in  1  SDA pin sample

Behaviour:
- Reset values: scl_o=1, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=16'h0000, state=IDLE.
- Reset mid-transaction: the same values apply on the next edge. No STOP is generated.
- Quarter tick: a counter 0..CLK_DIV-1 produces a 1-cycle qtick. A 2-bit phase advances on each qtick. The counter is held at 0 in IDLE.
- Bit slot = phases 0..3.
  - SCL is low in phases 0-1 and high in phases 2-3.
  - SDA is updated at phase 0 entry.
  - sda_i is sampled on the qtick that ends phase 2.
- States: IDLE, START, ADDR_W, REG, WR_H, WR_L, RSTART, ADDR_R, RD_H, RD_L, STOP, DONE.
- IDLE -> START on start=1. Inputs are latched and busy rises on the next cycle. start while busy is ignored.
- START: SDA released and SCL high for phases 0-1, SDA low in phases 2-3, SCL low at the end.
- Byte states send 8 bits MSB first, then a 9th ACK bit slot with SDA released.
  - ACK = sda_i sampled 0. NACK sets ack_err and goes to STOP.
  - After ADDR_W -> REG.
  - After REG -> WR_H if rw=0, RSTART if rw=1.
  - WR_H -> WR_L -> STOP.
- RSTART: SDA released with SCL low (phase 0), SCL high (phases 1-2), SDA low (phase 3) -> ADDR_R (0xB9).
- RD_H / RD_L: SDA released for 8 bits, shifting sda_i MSB first.
  - 9th bit: master ACK (sda_oe=1) after RD_H, NACK (sda_oe=0) after RD_L.
  - rd_data is written in the cycle STOP is entered from RD_L.
- STOP: SDA low with SCL low, then SCL high, then SDA released in phase 3 -> DONE.
- DONE: done=1 for one cycle, busy drops on the same edge -> IDLE.
  - A start asserted during DONE is ignored. start is accepted no earlier than the following cycle.
- Bit-slot counts:
  - Write = START + 4×9 + STOP = 38 slots = 152·CLK_DIV cycles from acceptance to done (±2).
  - Read = 1 + 18 + 1 + 27 + 1 = 48 slots.
- Clock stretching is unsupported: SCL is never sampled.

Decomposition:
- Package mt9v034_pkg holds:
  - state encoding (localparams)
  - DEV_ADDR constant
  - common register addresses: CHIP_VERSION 8'h00 (expected 16'h1324), RESET 8'h0C, READ_MODE 8'h0D
- Sub-module i2c_tick_gen: CLK_DIV counter plus phase counter, with enable input and qtick/phase outputs.

Test Plan:
- Write reg 8'h0D data 16'h0330 with slave model ACKing all bytes -> SDA bytes B8,0D,03,30; START/STOP conditions correct; done after 38 slots; ack_err=0.
- Read reg 8'h00 with slave returning 16'h1324 -> bytes B8,00, repeated start, B9; master ACK then NACK; rd_data=16'h1324; done after 48 slots.
- Slave NACKs the address byte -> STOP follows the 9th bit immediately; done with ack_err=1; rd_data unchanged.
- start pulsed while busy, and again during DONE -> ignored; exactly one transaction runs.
- reset asserted mid-WR_H -> next cycle scl_o=1, sda_oe=0, busy=0; a new start then completes normally.
- SCL period check with CLK_DIV=4 -> SCL period exactly 16 clk; SDA never changes while SCL is high except at START, RSTART and STOP.
